// File: rtl/alu_defs_pkg.sv
// Shared definitions for the R-type ALU / multiply-divide core: funct codes, engine states, op classes.
// ALU_DIVU_EN selects whether DIVU is a legal (multi-cycle) op or reported as illegal.
package alu_defs_pkg;

   localparam logic [5:0] FN_SLL   = 6'd0;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_SLT   = 6'd42;

   typedef enum logic {IDLE, RUN} engStateE;

   typedef enum logic [1:0] {OC_SINGLE, OC_MULDIV, OC_ILLEGAL} opClassE;

   function automatic opClassE opClassOf(input logic [5:0] f);
      opClassE c;
      case (f)
         FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
         FN_SLL, FN_SRL, FN_MFHI, FN_MFLO: c = OC_SINGLE;
         FN_MULTU:                         c = OC_MULDIV;
`ifdef ALU_DIVU_EN
         FN_DIVU:                          c = OC_MULDIV;
`endif
         default:                          c = OC_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_muldiv_core_seq_muldiv.sv
// Iterative engine: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle, WIDTH steps.
// Divider datapath exists only when ALU_DIVU_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands loaded on start
// RUN   | one iteration per cycle; cntQ counts down to 0, final step result goes out with done
module seq_muldiv
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             isDiv,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resHi,
   output logic [WIDTH-1:0] resLo
);

   engStateE         stateQ, stateD;
   logic [SHW-1:0]   cntQ;
   logic [WIDTH-1:0] hiQ, loQ, opBQ;
   logic             isDivQ;
   logic [WIDTH-1:0] stepHi, stepLo;
   logic [WIDTH:0]   mulSum;

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (start) stateD = RUN;
         RUN:     if (cntQ == '0) stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   assign busy = (stateQ == RUN);
   assign done = (stateQ == RUN) && (cntQ == '0);

   // hiQ is the running product high half (multiply) or partial remainder (divide)
   assign mulSum = {1'b0, hiQ} + (loQ[0] ? {1'b0, opBQ} : '0);

`ifdef ALU_DIVU_EN
   logic [WIDTH:0] divShift, divDiff;
   assign divShift = {hiQ, loQ[WIDTH-1]};
   assign divDiff  = divShift - {1'b0, opBQ};

   always_comb begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], loQ[WIDTH-1:1]};
      if (isDivQ) begin
         stepHi = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
         stepLo = {loQ[WIDTH-2:0], ~divDiff[WIDTH]};
      end
   end
`else
   logic unusedDiv;
   assign unusedDiv = isDivQ;

   always_comb begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], loQ[WIDTH-1:1]};
   end
`endif

   assign resHi = stepHi;
   assign resLo = stepLo;

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= IDLE;
         cntQ   <= '0;
         hiQ    <= '0;
         loQ    <= '0;
         opBQ   <= '0;
         isDivQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (stateQ == IDLE && start) begin
            cntQ   <= SHW'(WIDTH - 1);
            hiQ    <= '0;
            loQ    <= opA;
            opBQ   <= opB;
            isDivQ <= isDiv;
         end else if (stateQ == RUN) begin
            cntQ <= cntQ - 1'b1;
            hiQ  <= stepHi;
            loQ  <= stepLo;
         end
      end
   end

endmodule

// File: rtl/alu_muldiv_core.sv
// R-type execute ALU: valid/ready handshake, single-cycle datapath, HI/LO registers fed by seq_muldiv.
// DIVU is legal only when ALU_DIVU_EN is defined.
module alu_muldiv_core
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             illegal,
   output logic             busy
);

   logic             accept;
   opClassE          opClass;
   logic             engDone;
   logic [WIDTH-1:0] engHi, engLo;
   logic [WIDTH-1:0] hiQ, loQ;
   logic [WIDTH-1:0] aluRes;

   assign in_ready = ~busy;
   assign accept   = in_valid & in_ready;
   assign opClass  = opClassOf(funct);

   seq_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) uEngine (
      .clk   (clk),
      .reset (reset),
      .start (accept && opClass == OC_MULDIV),
      .isDiv (funct == FN_DIVU),
      .opA   (data_a),
      .opB   (data_b),
      .busy  (busy),
      .done  (engDone),
      .resHi (engHi),
      .resLo (engLo)
   );

   // Illegal functs fall through to zero, which is exactly the required out_data
   always_comb begin
      aluRes = '0;
      case (funct)
         FN_AND:  aluRes = data_a & data_b;
         FN_OR:   aluRes = data_a | data_b;
         FN_ADD:  aluRes = data_a + data_b;
         FN_SUB:  aluRes = data_a - data_b;
         FN_SLT:  aluRes[0] = $signed(data_a) < $signed(data_b);
         FN_SLL:  aluRes = data_a << data_b[SHW-1:0];
         FN_SRL:  aluRes = data_a >> data_b[SHW-1:0];
         FN_MFHI: aluRes = hiQ;
         FN_MFLO: aluRes = loQ;
         default: aluRes = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         illegal   <= 1'b0;
         hiQ       <= '0;
         loQ       <= '0;
      end else begin
         out_valid <= accept && (opClass != OC_MULDIV);
         illegal   <= accept && (opClass == OC_ILLEGAL);
         if (accept && opClass != OC_MULDIV) out_data <= aluRes;
         if (engDone) begin
            hiQ <= engHi;
            loQ <= engLo;
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv_core.sv
// Scoreboard bench for alu_muldiv_core (WIDTH=32); expectations follow ALU_DIVU_EN the same way as the DUT build.
module tb_alu_muldiv_core;
   import alu_defs_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  funct = '0;
   logic [31:0] data_a = '0;
   logic [31:0] data_b = '0;
   logic        out_valid;
   logic [31:0] out_data;
   logic        illegal;
   logic        busy;

   typedef struct {
      logic [31:0] data;
      logic        ill;
      string       name;
   } expT;

   expT expQ[$];
   int  nCompared = 0;
   int  nMismatch = 0;
   int  cyc = 0;

   alu_muldiv_core #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct     (funct),
      .data_a    (data_a),
      .data_b    (data_b),
      .out_valid (out_valid),
      .out_data  (out_data),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (expQ.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL unexpected_out_valid: got data 0x%08h with empty scoreboard", out_data);
         end else begin
            expT e;
            e = expQ.pop_front();
            chk({e.name, "_data"}, out_data, e.data);
            chk({e.name, "_illegal"}, {31'b0, illegal}, {31'b0, e.ill});
         end
      end
   end

   task automatic expect_res(input string nm, input logic [31:0] d, input logic ill);
      expT e;
      e.data = d;
      e.ill  = ill;
      e.name = nm;
      expQ.push_back(e);
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      funct    = f;
      data_a   = a;
      data_b   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_a   = $urandom;
      data_b   = $urandom;
   endtask

   initial begin
      int c0;
      int busyCnt;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      expect_res("add_wrap", 32'h8000_0000, 1'b0);
      issue(FN_ADD, 32'h7FFF_FFFF, 32'h1);
      expect_res("sub_wrap", 32'hFFFF_FFFF, 1'b0);
      issue(FN_SUB, 32'h0, 32'h1);
      expect_res("slt_neg", 32'h1, 1'b0);
      issue(FN_SLT, 32'hFFFF_FFFF, 32'h1);
      expect_res("slt_pos", 32'h0, 1'b0);
      issue(FN_SLT, 32'h1, 32'hFFFF_FFFF);
      expect_res("sll_mask", 32'h2, 1'b0);
      issue(FN_SLL, 32'h1, 32'h21);
      expect_res("srl_31", 32'h1, 1'b0);
      issue(FN_SRL, 32'h8000_0000, 32'd31);
      expect_res("mfhi_init", 32'h0, 1'b0);
      issue(FN_MFHI, 32'h0, 32'h0);

      issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      busyCnt = 0;
      @(negedge clk);
      chk("multu_in_ready_low", {31'b0, in_ready}, 32'd0);
      while (busy && busyCnt < 100) begin
         busyCnt++;
         data_a = $urandom;
         @(negedge clk);
      end
      chk("multu_busy_cycles", busyCnt, 32'd32);
      expect_res("multu_hi", 32'hFFFF_FFFE, 1'b0);
      issue(FN_MFHI, 32'h0, 32'h0);
      expect_res("multu_lo", 32'h0000_0001, 1'b0);
      issue(FN_MFLO, 32'h0, 32'h0);

`ifdef ALU_DIVU_EN
      issue(FN_DIVU, 32'd100, 32'd7);
      expect_res("divu_q", 32'd14, 1'b0);
      issue(FN_MFLO, 32'h0, 32'h0);
      expect_res("divu_r", 32'd2, 1'b0);
      issue(FN_MFHI, 32'h0, 32'h0);
      issue(FN_DIVU, 32'd5, 32'd0);
      expect_res("div0_q", 32'hFFFF_FFFF, 1'b0);
      issue(FN_MFLO, 32'h0, 32'h0);
      expect_res("div0_r", 32'd5, 1'b0);
      issue(FN_MFHI, 32'h0, 32'h0);
`else
      expect_res("divu_illegal", 32'h0, 1'b1);
      issue(FN_DIVU, 32'd100, 32'd7);
      @(negedge clk);
      chk("divu_no_busy", {31'b0, busy}, 32'd0);
      expect_res("divu_keep_lo", 32'h0000_0001, 1'b0);
      issue(FN_MFLO, 32'h0, 32'h0);
      expect_res("divu_keep_hi", 32'hFFFF_FFFE, 1'b0);
      issue(FN_MFHI, 32'h0, 32'h0);
`endif

      expect_res("illegal_3f", 32'h0, 1'b1);
      issue(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0);
      c0 = cyc;
      expect_res("b2b_add", 32'h0000_0005, 1'b0);
      issue(FN_ADD, 32'd2, 32'd3);
      expect_res("b2b_or", 32'hFF0F_00F0, 1'b0);
      issue(FN_OR, 32'hF00F_00F0, 32'h0F00_0000);
      expect_res("b2b_and", 32'h0000_0F00, 1'b0);
      issue(FN_AND, 32'h00FF_FF00, 32'h0000_0FFF);
      chk("b2b_cycles", cyc - c0, 32'd3);

      issue(FN_MULTU, 32'h1234_5678, 32'h0000_0100);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (40) @(negedge clk);
      expect_res("rst_mfhi", 32'h0, 1'b0);
      issue(FN_MFHI, 32'h0, 32'h0);
      expect_res("rst_mflo", 32'h0, 1'b0);
      issue(FN_MFLO, 32'h0, 32'h0);

      begin
         int n;
         n = 0;
         while (expQ.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      chk("scoreboard_drained", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
